imm_gen_pipe: RTL
=================

// Module: imm_gen_pipe
// PURPOSE
//  Pipelined, parametrised RV32I/RV64I immediate generator for the decode stage.
//  Decodes all base immediate formats (I, S, B, U, J) and sign-extends them to XLEN.
//  Carries an opaque tag (PC/ROB id) alongside, through PIPE_STAGES valid/ready registers.
//  Supports back-pressure and flush.
//  Feeds the ALU operand mux and the branch-target adder.
// PARAMETERS
//  XLEN         32  datapath width; 32 or 64 only (other values: elaboration error)
//  PIPE_STAGES  1   register stages between input and output; 1 or 2
//  TAG_W        32  width of tag carried unchanged with each instruction
// PORTS
//  clk_i        in   1        clock, rising edge
//  rst_ni       in   1        reset; synchronous, active-low
//  flush_i      in   1        kill every in-flight entry
//  in_valid_i   in   1        instruction word valid
//  in_ready_o   out  1        stage can accept this cycle
//  instr_i      in   32       instruction word
//  tag_i        in   TAG_W    tag accompanying instr_i
//  out_valid_o  out  1        imm_o/imm_type_o/tag_o valid
//  out_ready_i  in   1        consumer accepts this cycle
//  imm_o        out  XLEN     sign-extended immediate
//  imm_type_o   out  3        0 NONE, 1 I, 2 S, 3 B, 4 U, 5 J
//  tag_o        out  TAG_W    tag of the output entry
// BEHAVIOUR
//  Decode (combinational, on opcode = instr_i[6:0]):
//   - I (0000011 LOAD, 0010011 OP-IMM, 1100111 JALR; 0011011 OP-IMM-32 only when XLEN=64):
//     sext(instr[31:20])
//   - S (0100011): sext({instr[31:25],instr[11:7]})
//   - B (1100011): sext({instr[31],instr[7],instr[30:25],instr[11:8],1'b0})
//   - U (0110111 LUI, 0010111 AUIPC): sext({instr[31:12],12'b0})
//     The sign extension applies for XLEN=64.
//   - J (1101111): sext({instr[31],instr[19:12],instr[20],instr[30:21],1'b0})
//   - Any other opcode: imm = 0, type NONE.
//     The entry still flows through the pipeline; no error is raised.
//   - Every sign extension replicates instr[31] to XLEN bits.
//  Pipeline:
//   - Each stage k holds {valid, imm, type, tag}.
//   - Stage k loads when it is empty or stage k+1 (the output, for the last stage) is draining.
//   - Last stage drains when out_valid_o && out_ready_i.
//   - in_ready_o = !valid[0] || stage0 advancing. This is combinational from out_ready_i.
//     No skid buffer.
//   - Decode is performed before stage 0.
//   - Latency = PIPE_STAGES cycles from input handshake to out_valid_o, with no bubbles.
//   - Throughput is 1/cycle while out_ready_i=1.
//   - Stalled (out_valid_o=1, out_ready_i=0): imm_o/imm_type_o/tag_o are held stable.
//   - Payload regs load only on a stage-advance; they are not cleared on pop.
//  Flush:
//   - flush_i=1: all valid bits are cleared next edge.
//   - An input handshake in the same cycle is discarded.
//   - in_ready_o stays as computed; the accepted word is simply dropped.
//   - flush_i beats out_ready_i: the output handshake still counts for the consumer
//     that cycle; the entry is gone next cycle either way.
//  Reset (rst_ni=0 at an edge):
//   - All valid bits are cleared; imm_o=0, imm_type_o=0, tag_o=0.
//   - Effect is next edge; mid-stream entries are lost.
//   - in_ready_o is 1 the cycle after reset deasserts.
//  Simultaneous push into a full pipe while the output pops: accepted, with no loss and
//  no duplication.
// STRUCTURE
//  - Shared package: opcode localparams (OPC_LOAD, OPC_OPIMM, OPC_OPIMM32, OPC_JALR,
//    OPC_STORE, OPC_BRANCH, OPC_LUI, OPC_AUIPC, OPC_JAL) and the 3-bit IMM_* type
//    encodings. The ALU-mux decoder imports them.
//  - One sub-module: imm_decode (purely combinational: instr, XLEN -> imm, type).
//  - Stage registers are generated inline with a generate loop over PIPE_STAGES.
// TESTING (XLEN=32, PIPE_STAGES=1 unless noted; out_ready_i=1 unless noted)
//  1. Formats.
//     - 0xFFF00093 -> imm 0xFFFFFFFF, I.
//     - 0xFE20AE23 -> 0xFFFFFFFC, S.
//     - 0xFE000CE3 -> 0xFFFFFFF8, B.
//     - 0x123452B7 -> 0x12345000, U.
//     - 0x001000EF -> 0x00000800, J.
//     - 0x00000073 -> 0, NONE.
//     - Each result appears one cycle after its handshake.
//  2. XLEN=64.
//     - 0xFFF00093 -> 0xFFFFFFFFFFFFFFFF.
//     - 0x800002B7 -> 0xFFFFFFFF80000000.
//     - 0xFFF0009B (OP-IMM-32) -> all-ones, I.
//  3. Back-pressure, PIPE_STAGES=2.
//     - Stream tags 1..6 with out_ready_i=0 for 4 cycles.
//     - in_ready_o drops after 2 accepts; outputs are held stable.
//     - Then tags 1..6 come out in order, with no gaps once out_ready_i=1.
//  4. Flush.
//     - Fill 2 stages, then assert flush_i with in_valid_i=1.
//     - Next cycle out_valid_o=0; the flushed-cycle word never appears.
//     - The following word appears after 2 cycles.
//  5. Reset mid-stream.
//     - Hold rst_ni=0 for 1 edge with the pipe full.
//     - out_valid_o=0, imm_o=0, tag_o=0; in_ready_o=1 the next cycle.
//  6. Random.
//     - 10k random instructions with random out_ready_i against a reference model.
//     - Order, values and types must match; assert hold-stable under stall.

Source files
------------

// File: rtl/imm_gen_pipe_pkg.sv
// Shared RV32I/RV64I opcode constants and immediate-type encodings used by the
// immediate generator and the ALU operand-mux decoder.
package imm_gen_pipe_pkg;

  localparam logic [6:0] OPC_LOAD    = 7'b0000011;
  localparam logic [6:0] OPC_OPIMM   = 7'b0010011;
  localparam logic [6:0] OPC_OPIMM32 = 7'b0011011;
  localparam logic [6:0] OPC_JALR    = 7'b1100111;
  localparam logic [6:0] OPC_STORE   = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH  = 7'b1100011;
  localparam logic [6:0] OPC_LUI     = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC   = 7'b0010111;
  localparam logic [6:0] OPC_JAL     = 7'b1101111;

  typedef enum logic [2:0] {
    IMM_NONE = 3'd0,
    IMM_I    = 3'd1,
    IMM_S    = 3'd2,
    IMM_B    = 3'd3,
    IMM_U    = 3'd4,
    IMM_J    = 3'd5
  } imm_type_e;

endpackage

// File: rtl/imm_decode.sv
// Combinational immediate decoder: extracts the I/S/B/U/J immediate from an
// instruction word and sign-extends it (from instr[31]) to XLEN bits.
module imm_decode
  import imm_gen_pipe_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:0]     instr,
  output logic [XLEN-1:0] imm,
  output imm_type_e       imm_type
);

  logic [31:0] imm32;

  always_comb begin
    // NOTE: defaults first so every path assigns both outputs and no latch is inferred.
    imm32    = '0;
    imm_type = IMM_NONE;
    case (instr[6:0])
      OPC_LOAD, OPC_OPIMM, OPC_JALR: begin
        imm32    = {{20{instr[31]}}, instr[31:20]};
        imm_type = IMM_I;
      end
      OPC_OPIMM32: begin
        // Word-immediate ops only exist on RV64; on RV32 the opcode is unknown.
        if (XLEN == 64) begin
          imm32    = {{20{instr[31]}}, instr[31:20]};
          imm_type = IMM_I;
        end
      end
      OPC_STORE: begin
        imm32    = {{20{instr[31]}}, instr[31:25], instr[11:7]};
        imm_type = IMM_S;
      end
      OPC_BRANCH: begin
        imm32    = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
        imm_type = IMM_B;
      end
      OPC_LUI, OPC_AUIPC: begin
        imm32    = {instr[31:12], 12'b0};
        imm_type = IMM_U;
      end
      OPC_JAL: begin
        imm32    = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
        imm_type = IMM_J;
      end
      default: ;
    endcase
  end

  // Bit 31 of every 32-bit form is instr[31], so a signed widen finishes the job.
  assign imm = XLEN'($signed(imm32));

endmodule

// File: rtl/imm_gen_pipe.sv
// Pipelined immediate generator: decode, then PIPE_STAGES valid/ready register
// stages carrying {imm, type, tag}, with back-pressure and flush.
module imm_gen_pipe
  import imm_gen_pipe_pkg::*;
#(
  parameter int XLEN        = 32,
  parameter int PIPE_STAGES = 1,
  parameter int TAG_W       = 32
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             flush_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [31:0]      instr_i,
  input  logic [TAG_W-1:0] tag_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [XLEN-1:0]  imm_o,
  output logic [2:0]       imm_type_o,
  output logic [TAG_W-1:0] tag_o
);

  if (XLEN != 32 && XLEN != 64) begin : g_bad_xlen
    $error("imm_gen_pipe: XLEN must be 32 or 64");
  end
  if (PIPE_STAGES != 1 && PIPE_STAGES != 2) begin : g_bad_stages
    $error("imm_gen_pipe: PIPE_STAGES must be 1 or 2");
  end

  logic [XLEN-1:0] dec_imm;
  imm_type_e       dec_type;

  imm_decode #(.XLEN(XLEN)) u_decode (
    .instr    (instr_i),
    .imm      (dec_imm),
    .imm_type (dec_type)
  );

  logic [PIPE_STAGES-1:0] valid_vec;
  logic [PIPE_STAGES-1:0] en;

  // Stage k may load when it, or any stage downstream of it, has room or the
  // consumer is taking the output this cycle.
  always_comb begin : p_enable
    logic go;
    go = out_ready_i;
    en = '0;
    for (int k = PIPE_STAGES - 1; k >= 0; k--) begin
      go    = go || !valid_vec[k];
      en[k] = go;
    end
  end

  assign in_ready_o = en[0];

  for (genvar k = 0; k < PIPE_STAGES; k++) begin : g_stage
    logic             valid_q;
    logic [XLEN-1:0]  imm_q;
    imm_type_e        type_q;
    logic [TAG_W-1:0] tag_q;

    logic             valid_d;
    logic [XLEN-1:0]  imm_d;
    imm_type_e        type_d;
    logic [TAG_W-1:0] tag_d;

    if (k == 0) begin : g_head
      assign valid_d = in_valid_i;
      assign imm_d   = dec_imm;
      assign type_d  = dec_type;
      assign tag_d   = tag_i;
    end else begin : g_body
      assign valid_d = g_stage[k-1].valid_q;
      assign imm_d   = g_stage[k-1].imm_q;
      assign type_d  = g_stage[k-1].type_q;
      assign tag_d   = g_stage[k-1].tag_q;
    end

    // NOTE: state registers use non-blocking assignments so every stage samples
    // its upstream neighbour's pre-edge value.
    always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
        valid_q <= 1'b0;
        // NOTE: payload is reset too because the outputs must read zero after reset.
        imm_q   <= '0;
        type_q  <= IMM_NONE;
        tag_q   <= '0;
      end else begin
        if (flush_i) begin
          valid_q <= 1'b0;
        end else if (en[k]) begin
          valid_q <= valid_d;
        end
        // Payload only moves with a real entry; bubbles and pops leave it alone.
        if (en[k] && valid_d) begin
          imm_q  <= imm_d;
          type_q <= type_d;
          tag_q  <= tag_d;
        end
      end
    end

    assign valid_vec[k] = valid_q;
  end

  assign out_valid_o = g_stage[PIPE_STAGES-1].valid_q;
  assign imm_o       = g_stage[PIPE_STAGES-1].imm_q;
  assign imm_type_o  = g_stage[PIPE_STAGES-1].type_q;
  assign tag_o       = g_stage[PIPE_STAGES-1].tag_q;

endmodule
